// File: rtl/serial_andor_chain_pkg.sv
// Shared types, sizes and the AND-OR stage function for the serial chain evaluator.
// The bench scoreboard reuses andor_step so both sides agree on one definition.
package serial_andor_chain_pkg;

    localparam int unsigned N  = 5;
    localparam int unsigned CW = 3;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ACCUM = 2'd1;
    localparam state_t HOLD  = 2'd2;

    typedef struct packed {
        logic [N-1:0]  chain;
        logic [CW-1:0] count;
        logic          overflow;
    } result_t;

    function automatic logic andor_step(input logic c, input logic p, input logic g);
        return (c & p) | g;
    endfunction

endpackage

// File: rtl/serial_andor_chain_if.sv
// Beat stream in, result word out, for the serial AND-OR chain evaluator.
interface serial_andor_chain_if import serial_andor_chain_pkg::*; ();

    logic          in_valid;
    logic          in_ready;
    logic          in_first;
    logic          in_last;
    logic          in_seed;
    logic          in_p;
    logic          in_g;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_chain;
    logic [CW-1:0] out_count;
    logic          out_overflow;

    modport master (
        output in_valid, in_first, in_last, in_seed, in_p, in_g, out_ready,
        input  in_ready, out_valid, out_chain, out_count, out_overflow
    );

    modport slave (
        input  in_valid, in_first, in_last, in_seed, in_p, in_g, out_ready,
        output in_ready, out_valid, out_chain, out_count, out_overflow
    );

endinterface

// File: rtl/serial_andor_chain_stage_reg.sv
// Single-bit chain value register: load from seed, advance one stage, or hold.
// c_next_c exposes the value being written so the result word can capture it the same edge.
module andor_stage_reg import serial_andor_chain_pkg::*; (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic step,
    input  logic seed,
    input  logic p,
    input  logic g,
    output logic c,
    output logic c_next_c
);

    always_comb begin
        c_next_c = c;
        if (load) begin
            c_next_c = andor_step(seed, p, g);
        end else if (step) begin
            c_next_c = andor_step(c, p, g);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c <= 1'b0;
        end else begin
            c <= c_next_c;
        end
    end

endmodule

// File: rtl/serial_andor_chain.sv
// Serial AND-OR propagate chain: one stage per accepted beat, result word held until taken.
// in_ready/out_valid are flops loaded from the next state, so no input reaches an output combinationally.
module serial_andor_chain import serial_andor_chain_pkg::*; (
    input  logic                 clk,
    input  logic                 rst,
    serial_andor_chain_if.slave  bus
);

    state_t  state_q;
    state_t  state_d;
    result_t res_q;
    result_t res_d;
    logic    ready_q;
    logic    valid_q;
    logic    accept_c;
    logic    load_c;
    logic    step_c;
    logic    c_q;
    logic    c_next_c;

    assign accept_c = bus.in_valid & ready_q;
    assign load_c   = accept_c & bus.in_first & (state_q != HOLD);
    assign step_c   = accept_c & ~bus.in_first & (state_q == ACCUM);

    andor_stage_reg u_stage (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .step     (step_c),
        .seed     (bus.in_seed),
        .p        (bus.in_p),
        .g        (bus.in_g),
        .c        (c_q),
        .c_next_c (c_next_c)
    );

    // Next state and result word; a first beat in ACCUM restarts exactly like IDLE.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (load_c) begin
                    res_d.chain    = '0;
                    res_d.chain[0] = c_next_c;
                    res_d.count    = CW'(1);
                    res_d.overflow = 1'b0;
                    state_d        = bus.in_last ? HOLD : ACCUM;
                end else if (step_c) begin
                    if (res_q.count < CW'(N)) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            if (CW'(i) == res_q.count) begin
                                res_d.chain[i] = c_next_c;
                            end
                        end
                        res_d.count = res_q.count + CW'(1);
                    end else begin
                        res_d.overflow = 1'b1;
                    end
                    if (bus.in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            ready_q <= (state_d != HOLD);
            valid_q <= (state_d == HOLD);
        end
    end

    assign bus.in_ready     = ready_q;
    assign bus.out_valid    = valid_q;
    assign bus.out_chain    = res_q.chain;
    assign bus.out_count    = res_q.count;
    assign bus.out_overflow = res_q.overflow;

endmodule
